// File: rtl/lcd_cmd_driver.sv
// lcd_cmd_driver: buffers LCD command/character writes from the LSU I/O decode
// and drives HD44780-style pins with setup, enable-pulse, hold and execution timing.
// Optional build macro LCD_INIT_SEQ_EN adds a power-up wait followed by an
// internal init sequence (0x38, 0x0C, 0x01, 0x06) before host commands are accepted.

package lcd_cmd_driver_pkg;
  // One buffered LCD transfer: register select plus byte
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_cmd_t;
endpackage

module lcd_cmd_driver
  import lcd_cmd_driver_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned T_SETUP_CYC = 2,
  parameter int unsigned T_EN_CYC    = 12,
  parameter int unsigned T_EXEC_CYC  = 2000,
  parameter int unsigned T_LONG_CYC  = 80000,
  parameter int unsigned T_PWRUP_CYC = 2000000
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_cmd_vld,
  input  logic                          i_cmd_rs,
  input  logic [7:0]                    i_cmd_data,
  output logic                          o_cmd_rdy,
  input  logic                          i_lcd_on,
  output logic                          o_lcd_on,
  output logic [7:0]                    o_lcd_data,
  output logic                          o_lcd_rs,
  output logic                          o_lcd_rw,
  output logic                          o_lcd_en,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W  = PTR_W + 1;
  localparam int unsigned T_MAX_A = (T_LONG_CYC > T_EXEC_CYC) ? T_LONG_CYC : T_EXEC_CYC;
  localparam int unsigned T_MAX_B = (T_MAX_A > T_EN_CYC) ? T_MAX_A : T_EN_CYC;
  localparam int unsigned T_MAX_C = (T_MAX_B > T_SETUP_CYC) ? T_MAX_B : T_SETUP_CYC;
  localparam int unsigned T_MAX   = (T_MAX_C > T_PWRUP_CYC) ? T_MAX_C : T_PWRUP_CYC;
  localparam int unsigned TMR_W   = $clog2(T_MAX + 1);

  localparam logic [TMR_W-1:0] LD_SETUP = TMR_W'(T_SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] LD_EN    = TMR_W'(T_EN_CYC - 1);
  localparam logic [TMR_W-1:0] LD_EXEC  = TMR_W'(T_EXEC_CYC - 1);
  localparam logic [TMR_W-1:0] LD_LONG  = TMR_W'(T_LONG_CYC - 1);
`ifdef LCD_INIT_SEQ_EN
  localparam logic [TMR_W-1:0] LD_PWRUP = TMR_W'(T_PWRUP_CYC - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_EXEC
`ifdef LCD_INIT_SEQ_EN
    , S_PWRUP
`endif
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [TMR_W-1:0]   r_tmr, w_tmr_nxt;
  lcd_cmd_t           r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [FCNT_W-1:0]  r_count, w_count_nxt;
  lcd_cmd_t           w_head, w_wr_cmd, w_load_cmd;
  logic               w_push, w_pop, w_load, w_long;
  logic [7:0]         r_lcd_data;
  logic               r_lcd_rs, r_lcd_en, r_busy, r_cmd_rdy, r_lcd_on;
`ifdef LCD_INIT_SEQ_EN
  logic               r_init_busy, w_init_busy_nxt;
  logic [1:0]         r_init_idx, w_init_idx_nxt;

  // Fixed HD44780 init bytes: 8-bit/2-line, display on, clear, entry mode
  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  endfunction
`endif

  assign w_head        = r_mem[r_rd_ptr];
  assign w_wr_cmd.rs   = i_cmd_rs;
  assign w_wr_cmd.data = i_cmd_data;
  assign w_push        = i_cmd_vld && r_cmd_rdy;
  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait
  assign w_long        = !r_lcd_rs && (r_lcd_data[7:2] == 6'd0) && (r_lcd_data != 8'd0);

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + FCNT_W'(1);
      2'b01:   w_count_nxt = r_count - FCNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Next-state, timer reload and pin-load decode for the pin sequencer
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = (r_tmr != '0) ? (r_tmr - TMR_W'(1)) : r_tmr;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_load_cmd  = w_head;
`ifdef LCD_INIT_SEQ_EN
    w_init_busy_nxt = r_init_busy;
    w_init_idx_nxt  = r_init_idx;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = S_SETUP;
          w_tmr_nxt   = LD_SETUP;
        end
      end
      S_SETUP: begin
        if (r_tmr == '0) begin
          w_state_nxt = S_PULSE;
          w_tmr_nxt   = LD_EN;
        end
      end
      S_PULSE: begin
        if (r_tmr == '0) begin
          w_state_nxt = S_HOLD;
          w_tmr_nxt   = LD_SETUP;
        end
      end
      S_HOLD: begin
        if (r_tmr == '0) begin
          w_state_nxt = S_EXEC;
          w_tmr_nxt   = w_long ? LD_LONG : LD_EXEC;
        end
      end
      S_EXEC: begin
        if (r_tmr == '0) begin
`ifdef LCD_INIT_SEQ_EN
          if (r_init_busy && (r_init_idx != 2'd3)) begin
            w_init_idx_nxt     = r_init_idx + 2'd1;
            w_load             = 1'b1;
            w_load_cmd.rs      = 1'b0;
            w_load_cmd.data    = init_byte(r_init_idx + 2'd1);
            w_state_nxt        = S_SETUP;
            w_tmr_nxt          = LD_SETUP;
          end else begin
            w_init_busy_nxt    = 1'b0;
            w_state_nxt        = S_IDLE;
          end
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end
`ifdef LCD_INIT_SEQ_EN
      S_PWRUP: begin
        if (r_tmr == '0) begin
          w_load          = 1'b1;
          w_load_cmd.rs   = 1'b0;
          w_load_cmd.data = init_byte(2'd0);
          w_state_nxt     = S_SETUP;
          w_tmr_nxt       = LD_SETUP;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wr_cmd;
  end

  // State, timer, FIFO pointers and all registered outputs
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
`ifdef LCD_INIT_SEQ_EN
      r_state     <= S_PWRUP;
      r_tmr       <= LD_PWRUP;
      r_init_busy <= 1'b1;
      r_init_idx  <= 2'd0;
      r_cmd_rdy   <= 1'b0;
`else
      r_state     <= S_IDLE;
      r_tmr       <= '0;
      r_cmd_rdy   <= 1'b1;
`endif
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_lcd_data  <= 8'd0;
      r_lcd_rs    <= 1'b0;
      r_lcd_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_lcd_on    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tmr    <= w_tmr_nxt;
      r_count  <= w_count_nxt;
      r_lcd_on <= i_lcd_on;
      r_lcd_en <= (w_state_nxt == S_PULSE);
      r_busy   <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_load) begin
        r_lcd_data <= w_load_cmd.data;
        r_lcd_rs   <= w_load_cmd.rs;
      end
`ifdef LCD_INIT_SEQ_EN
      r_init_busy <= w_init_busy_nxt;
      r_init_idx  <= w_init_idx_nxt;
      r_cmd_rdy   <= (w_count_nxt < FCNT_W'(FIFO_DEPTH)) && !w_init_busy_nxt;
`else
      r_cmd_rdy   <= (w_count_nxt < FCNT_W'(FIFO_DEPTH));
`endif
    end
  end

  assign o_cmd_rdy  = r_cmd_rdy;
  assign o_lcd_on   = r_lcd_on;
  assign o_lcd_data = r_lcd_data;
  assign o_lcd_rs   = r_lcd_rs;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = r_lcd_en;
  assign o_busy     = r_busy;
  assign o_fifo_cnt = r_count;

endmodule

// File: tb/tb_lcd_cmd_driver.sv
// tb_lcd_cmd_driver: randomized bench for lcd_cmd_driver with a command-level
// reference model (per-command pop time and service period, FIFO as a queue).
// Honours LCD_INIT_SEQ_EN by seeding the model with the init sequence.

module tb_lcd_cmd_driver;

  localparam int DEPTH = 4;
  localparam int TS    = 2;
  localparam int TE    = 4;
  localparam int TX    = 10;
  localparam int TL    = 40;
  localparam int TP    = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vld, rs, lcd_on_in;
  logic [7:0] data;
  logic       cmd_rdy, lcd_on, lcd_rs, lcd_rw, lcd_en, busy;
  logic [7:0] lcd_data;
  logic [2:0] fifo_cnt;

  always #5 clk = ~clk;

  lcd_cmd_driver #(
    .FIFO_DEPTH (DEPTH),
    .T_SETUP_CYC(TS),
    .T_EN_CYC   (TE),
    .T_EXEC_CYC (TX),
    .T_LONG_CYC (TL),
    .T_PWRUP_CYC(TP)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst_n),
    .i_cmd_vld (vld),
    .i_cmd_rs  (rs),
    .i_cmd_data(data),
    .o_cmd_rdy (cmd_rdy),
    .i_lcd_on  (lcd_on_in),
    .o_lcd_on  (lcd_on),
    .o_lcd_data(lcd_data),
    .o_lcd_rs  (lcd_rs),
    .o_lcd_rw  (lcd_rw),
    .o_lcd_en  (lcd_en),
    .o_busy    (busy),
    .o_fifo_cnt(fifo_cnt)
  );

  typedef struct { bit rs; bit [7:0] d; } cmd_t;
  typedef struct { int p; bit rs; bit [7:0] d; } pulse_t;

  int     n_checks = 0;
  int     n_errs   = 0;
  int     t;
  int     eng_free;
  int     rdy_edge;
  cmd_t   cq[$];
  pulse_t pq[$];
  bit     pend_push;
  cmd_t   pend_cmd;
  bit     on_drv;
  bit     on_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  function automatic bit is_long(bit r, bit [7:0] d);
    return (r == 1'b0) && (d >= 8'd1) && (d <= 8'd3);
  endfunction

  function automatic int exec_len(bit r, bit [7:0] d);
    return is_long(r, d) ? TL : TX;
  endfunction

  function automatic bit exp_rdy();
    return (cq.size() < DEPTH) && (t >= rdy_edge);
  endfunction

  function automatic bit exp_busy();
    return (cq.size() != 0) || (t < eng_free - 1);
  endfunction

  function automatic bit cur_valid();
    return (pq.size() > 0) && (pq[0].p <= t);
  endfunction

  function automatic bit exp_en();
    return cur_valid() && (t >= pq[0].p + TS) && (t < pq[0].p + TS + TE);
  endfunction

  function automatic bit [7:0] exp_data();
    return cur_valid() ? pq[0].d : 8'd0;
  endfunction

  function automatic bit exp_rs();
    return cur_valid() ? pq[0].rs : 1'b0;
  endfunction

  // Clear model to its post-reset view; t counts clock edges since reset release
  task automatic model_reset();
    cq.delete();
    pq.delete();
    t         = 0;
    eng_free  = 0;
    rdy_edge  = 0;
    pend_push = 1'b0;
    on_exp    = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    begin
      bit [7:0] seq [4];
      int p;
      seq[0] = 8'h38; seq[1] = 8'h0C; seq[2] = 8'h01; seq[3] = 8'h06;
      p = TP;
      for (int k = 0; k < 4; k++) begin
        pq.push_back('{p, 1'b0, seq[k]});
        p = p + 2 * TS + TE + exec_len(1'b0, seq[k]);
      end
      rdy_edge = p;
      eng_free = p + 1;
    end
`endif
  endtask

  // Advance the model across one clock edge
  task automatic model_edge();
    t++;
    if ((cq.size() > 0) && (t >= eng_free)) begin
      cmd_t c;
      c = cq.pop_front();
      pq.push_back('{t, c.rs, c.d});
      eng_free = t + 1 + 2 * TS + TE + exec_len(c.rs, c.d);
    end
    if (pend_push) cq.push_back(pend_cmd);
    while ((pq.size() > 1) && (pq[1].p <= t)) void'(pq.pop_front());
    on_exp = on_drv;
  endtask

  task automatic check_all();
    chk("en",     32'(lcd_en),   32'(exp_en()));
    chk("rdy",    32'(cmd_rdy),  32'(exp_rdy()));
    chk("busy",   32'(busy),     32'(exp_busy()));
    chk("cnt",    32'(fifo_cnt), 32'(cq.size()));
    chk("data",   32'(lcd_data), 32'(exp_data()));
    chk("rs",     32'(lcd_rs),   32'(exp_rs()));
    chk("rw",     32'(lcd_rw),   32'(0));
    chk("lcd_on", 32'(lcd_on),   32'(on_exp));
  endtask

  task automatic check_reset_state();
    chk("rst_en",   32'(lcd_en),   32'(0));
    chk("rst_busy", 32'(busy),     32'(0));
    chk("rst_cnt",  32'(fifo_cnt), 32'(0));
    chk("rst_data", 32'(lcd_data), 32'(0));
    chk("rst_rs",   32'(lcd_rs),   32'(0));
    chk("rst_on",   32'(lcd_on),   32'(0));
`ifdef LCD_INIT_SEQ_EN
    chk("rst_rdy",  32'(cmd_rdy),  32'(0));
`else
    chk("rst_rdy",  32'(cmd_rdy),  32'(1));
`endif
  endtask

  // Drive one cycle of inputs at the falling edge, then check after the next rising edge
  task automatic step(input bit v, input bit r, input bit [7:0] d);
    vld       = v;
    rs        = r;
    data      = d;
    on_drv    = 1'($urandom_range(0, 1));
    lcd_on_in = on_drv;
    pend_push = v && exp_rdy();
    pend_cmd  = '{r, d};
    @(posedge clk);
    @(negedge clk);
    model_edge();
    check_all();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_busy() || (cq.size() != 0)) && (n < budget)) begin
      step(1'b0, 1'b0, 8'h00);
      n++;
    end
    chk("drain_timeout", 32'(n < budget), 32'(1));
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic random_traffic(input int cycles);
    bit       v, r;
    bit [7:0] d;
    for (int i = 0; i < cycles; i++) begin
      v = ($urandom_range(0, 99) < 35);
      r = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      step(v, r, d);
    end
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    vld       = 1'b0;
    rs        = 1'b0;
    data      = 8'h00;
    lcd_on_in = 1'b0;
    on_drv    = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_reset_state();
    drain(400);

    // Single character, then a long (clear) and a normal instruction
    step(1'b1, 1'b1, 8'h41);
    drain(100);
    step(1'b1, 1'b0, 8'h01);
    drain(100);
    step(1'b1, 1'b0, 8'h80);
    drain(100);
    step(1'b1, 1'b0, 8'h02);
    drain(100);

    // Six back-to-back pushes against a four-deep FIFO
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 8'h30 + 8'(i));
    drain(300);

    random_traffic(600);
    drain(1000);

    // Reset while EN is high
    step(1'b1, 1'b1, 8'h5A);
    n = 0;
    while (!exp_en() && (n < 50)) begin
      step(1'b0, 1'b0, 8'h00);
      n++;
    end
    chk("wait_en", 32'(n < 50), 32'(1));
    chk("pre_rst_en", 32'(lcd_en), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("async_en",   32'(lcd_en),   32'(0));
    chk("async_cnt",  32'(fifo_cnt), 32'(0));
    chk("async_busy", 32'(busy),     32'(0));
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    check_reset_state();
    drain(400);

    random_traffic(300);
    drain(1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
